// File: rtl/seven_seg_mux_n_if.sv
// Host-side signal bundle for the multiplexed seven-segment driver.
`timescale 1ns/1ps
interface seven_seg_mux_n_if #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BRIGHT_W   = 4
);
   logic [4*NUM_DIGITS-1:0] value_in;
   logic                    value_vld;
   logic                    mode_bcd;
   logic                    lz_blank;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [BRIGHT_W-1:0]     brightness;
   logic                    display_en;
   logic                    busy;
   logic                    ovf;
   logic [NUM_DIGITS-1:0]   seg_an;
   logic [7:0]              seg_cat;

   modport master (
      output value_in, value_vld, mode_bcd, lz_blank, dp_in, brightness, display_en,
      input  busy, ovf, seg_an, seg_cat
   );

   modport slave (
      input  value_in, value_vld, mode_bcd, lz_blank, dp_in, brightness, display_en,
      output busy, ovf, seg_an, seg_cat
   );
endinterface

// File: rtl/seven_seg_mux_n.sv
// N-digit multiplexed seven-segment driver: frame-synchronous loading,
// sequential binary-to-BCD, leading-zero blanking, decimal points and PWM dimming.
`timescale 1ns/1ps
module seven_seg_mux_n #(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned DIV_CNT        = 1024,
   parameter int unsigned BRIGHT_W       = 4,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               sys_rst_n,
   seven_seg_mux_n_if.slave   bus
);
   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned BCD_W = 4 * (NUM_DIGITS + 1);
   localparam int unsigned DIV_W = $clog2(DIV_CNT);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(VAL_W + 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? '1 : '0;
   localparam logic [7:0]            CAT_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   typedef enum logic {S_IDLE, S_CONV} state_e;

   logic [DIV_W-1:0]    div_q;
   logic [BRIGHT_W-1:0] pwm_q;
   logic [IDX_W-1:0]    idx_q;
   logic                tick_c, pwm_wrap_c, frame_c;

   state_e              state_q, state_d;
   logic                busy_q, busy_d;
   logic                ovf_q, ovf_d;
   logic                pend_q, pend_d;
   logic [VAL_W-1:0]    shadow_q, shadow_d;
   logic [VAL_W-1:0]    disp_q, disp_d;
   logic [VAL_W-1:0]    bin_q, bin_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj_c;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                load_c;

   logic [3:0]            nib_c;
   logic                  hi_nz_c, blank_c, dp_c;
   logic [6:0]            seg7_c;
   logic [7:0]            cat_c;
   logic [NUM_DIGITS-1:0] an_c;
   logic [NUM_DIGITS-1:0] seg_an_q;
   logic [7:0]            seg_cat_q;

   assign tick_c     = (div_q == DIV_W'(DIV_CNT - 1));
   assign pwm_wrap_c = tick_c && (pwm_q == '1);
   assign frame_c    = pwm_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign load_c     = bus.value_vld && !busy_q;

   // Scan timebase: prescaler -> PWM step -> digit index.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_q <= '0;
         pwm_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= tick_c ? '0 : div_q + DIV_W'(1);
         if (tick_c)     pwm_q <= pwm_q + BRIGHT_W'(1);
         if (pwm_wrap_c) idx_q <= frame_c ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         pend_q   <= 1'b0;
         shadow_q <= '0;
         disp_q   <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         pend_q   <= pend_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
      end
   end

   // Load path and double-dabble; a boundary transfer uses the old shadow so a
   // coincident load stays pending for the next frame.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      ovf_d     = ovf_q;
      pend_d    = pend_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      bcd_adj_c = bcd_q;
      for (int k = 0; k < NUM_DIGITS + 1; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj_c[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      if (frame_c && pend_q) begin
         disp_d = shadow_q;
         pend_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (load_c) begin
               if (bus.mode_bcd) begin
                  state_d = S_CONV;
                  busy_d  = 1'b1;
                  bin_d   = bus.value_in;
                  bcd_d   = '0;
                  cnt_d   = '0;
               end else begin
                  shadow_d = bus.value_in;
                  pend_d   = 1'b1;
                  ovf_d    = 1'b0;
               end
            end
         end
         S_CONV: begin
            bcd_d = {bcd_adj_c[BCD_W-2:0], bin_q[VAL_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(VAL_W - 1)) begin
               state_d  = S_IDLE;
               busy_d   = 1'b0;
               shadow_d = bcd_d[VAL_W-1:0];
               ovf_d    = |bcd_d[BCD_W-1:VAL_W];
               pend_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Current-digit decode: glyph, blanking, dash override, anode gating.
   always_comb begin
      nib_c   = '0;
      hi_nz_c = 1'b0;
      dp_c    = 1'b0;
      an_c    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_c   = disp_q[4*i +: 4];
            dp_c    = bus.dp_in[i];
            an_c[i] = bus.display_en && (pwm_q <= bus.brightness);
         end
         if ((IDX_W'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'd0)) hi_nz_c = 1'b1;
      end
      blank_c = bus.lz_blank && (idx_q != '0) && !hi_nz_c;
      case (nib_c)
         4'h0:    seg7_c = 7'h3F;
         4'h1:    seg7_c = 7'h06;
         4'h2:    seg7_c = 7'h5B;
         4'h3:    seg7_c = 7'h4F;
         4'h4:    seg7_c = 7'h66;
         4'h5:    seg7_c = 7'h6D;
         4'h6:    seg7_c = 7'h7D;
         4'h7:    seg7_c = 7'h07;
         4'h8:    seg7_c = 7'h7F;
         4'h9:    seg7_c = 7'h6F;
         4'hA:    seg7_c = 7'h77;
         4'hB:    seg7_c = 7'h7C;
         4'hC:    seg7_c = 7'h39;
         4'hD:    seg7_c = 7'h5E;
         4'hE:    seg7_c = 7'h79;
         default: seg7_c = 7'h71;
      endcase
      if (ovf_q)        seg7_c = 7'h40;
      else if (blank_c) seg7_c = 7'h00;
      cat_c = {dp_c, seg7_c};
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         seg_an_q  <= AN_OFF;
         seg_cat_q <= CAT_OFF;
      end else begin
         seg_an_q  <= AN_ACTIVE_LOW  ? ~an_c  : an_c;
         seg_cat_q <= SEG_ACTIVE_LOW ? ~cat_c : cat_c;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.ovf     = ovf_q;
   assign bus.seg_an  = seg_an_q;
   assign bus.seg_cat = seg_cat_q;
endmodule

// File: doc/seven_seg_mux_n.md
Name: seven_seg_mux_n

Overview:
Parametrised multiplexed N-digit seven-segment display driver, successor to the fixed 4-digit hex driver on the board top. Adds configurable digit count and polarity, tear-free frame-synchronous value loading, a sequential binary-to-BCD mode with overflow indication, leading-zero blanking, per-digit decimal points and PWM brightness. Sits at board level and is driven by status/debug values from the video pipeline.

Parameters:
NUM_DIGITS, 4, number of digits; value width is 4*NUM_DIGITS.
DIV_CNT, 1024, prescaler period in clk cycles per PWM step (>=2).
BRIGHT_W, 4, PWM/brightness width; each digit slot is 2^BRIGHT_W PWM steps.
AN_ACTIVE_LOW, 1, 1 = anodes active-low.
SEG_ACTIVE_LOW, 1, 1 = cathodes active-low.

Ports:
clk  in  1  single clock domain.
sys_rst_n  in  1  asynchronous active-low reset.
value_in  in  4*NUM_DIGITS  value to display (hex nibbles or unsigned binary).
value_vld  in  1  one-cycle load strobe.
mode_bcd  in  1  0 = hex nibbles, 1 = binary converted to decimal; sampled with value_vld.
lz_blank  in  1  1 = blank leading zero digits.
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit, bit 0 = rightmost.
brightness  in  BRIGHT_W  PWM duty code.
display_en  in  1  0 = all anodes inactive.
busy  out  1  BCD conversion in progress.
ovf  out  1  last BCD value exceeded 10^NUM_DIGITS-1.
seg_an  out  NUM_DIGITS  registered anode enables, bit i = digit i.
seg_cat  out  8  registered cathodes {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (async): seg_an all inactive, seg_cat all inactive (per polarity), busy=0, ovf=0, shadow/display registers 0, digit index 0, prescaler 0, pwm_cnt 0. Reset mid-conversion aborts it; no partial result is kept.
- Prescaler counts 0..DIV_CNT-1 and asserts tick on DIV_CNT-1. On tick pwm_cnt increments; when pwm_cnt wraps from 2^BRIGHT_W-1 to 0, digit index advances and wraps NUM_DIGITS-1 -> 0 (frame boundary).
- Anode of current digit active iff display_en=1 and pwm_cnt <= brightness; brightness=0 gives duty 1/2^BRIGHT_W, all-ones gives 100%. Only one anode is ever active.
- seg_an/seg_cat are registered; both update on the same clk edge (1-cycle latency from index/pwm change).
- Load, hex mode: value_vld with busy=0 latches value_in into shadow and sets pending; shadow copies to display register at the next frame boundary, then pending clears. ovf clears on hex load.
- Load, BCD mode: value_vld with busy=0 latches value_in, sets busy next cycle, runs double-dabble with NUM_DIGITS+1 BCD digits, one bit per clk: busy high exactly 4*NUM_DIGITS cycles. On completion busy=0, lower NUM_DIGITS BCD digits go to shadow with pending set; ovf=1 iff extra top digit nonzero. While ovf=1, all digits display dash (g only).
- value_vld while busy=1 is ignored. value_vld coincident with a frame boundary: the previous shadow transfers, the new value goes to shadow and stays pending until the next boundary. A second load before transfer overwrites shadow.
- Segment coding: standard 0-9, A, b, C, d, E, F; active-high a..g pattern inverted when SEG_ACTIVE_LOW=1 (dp included).
- Leading-zero blanking (lz_blank=1): digits above the most significant nonzero digit show no segments; digit 0 is never blanked; dp still follows dp_in. Not applied to the dash pattern.
- lz_blank, dp_in, brightness and display_en are used live, with no frame synchronisation.

Test Plan:
- Reset: hold sys_rst_n=0 -> seg_an=4'hF, seg_cat=8'hFF, busy=0, ovf=0; release -> digit 0 scans first, digits cycle 0,1,2,3,0.
- Hex load 16'h1A3F, DIV_CNT=4, brightness=all-ones -> after next frame boundary digits 3..0 show 1, A, 3, F (cat 8'hF9, 8'h88, 8'hB0, 8'h8E, active-low); no change mid-frame.
- BCD load 16'd1234 -> busy high exactly 16 cycles, digits show 1,2,3,4, ovf=0; load 16'd65535 -> ovf=1, all digits 8'hBF (dash).
- lz_blank=1 with hex 16'h0005 -> digits 3..1 show 8'hFF, digit 0 shows 8'h92; with value 0, digit 0 shows 0 (8'hC0); dp_in=4'b0100 lights dp on digit 2 even while blanked.
- brightness=0, BRIGHT_W=4 -> each anode active 1 of 16 PWM steps; display_en=0 -> seg_an=4'hF.
- value_vld pulsed during busy -> ignored, result equals first value; sys_rst_n asserted mid-conversion -> busy=0 immediately, display shows 0.
